// File: rtl/ibex_l2_rf_port_sched_if.sv
// rtl/ibex_l2_rf_port_sched_if.sv - operand-read, writeback and L2 port bundle for the L2 RF port scheduler
//
// Purpose: groups the ID-stage operand fetch handshake, the writeback push channel
//          and the single L2 register-file port into one interface.
// Signals:
//   rd_req, rd_need_a, rd_need_b, raddr_a, raddr_b  operand fetch request (ID stage -> scheduler)
//   rdata_a, rdata_b, rd_done, stall                operand fetch response (scheduler -> ID stage)
//   wr_req, waddr, wdata                             writeback push (WB stage -> scheduler)
//   wr_full                                          write buffer full (scheduler -> WB stage)
//   l2_addr, l2_we, l2_wdata                         L2 port command (scheduler -> L2 bank)
//   l2_rdata                                         L2 port read data (L2 bank -> scheduler)
// Modports: slave = scheduler side, master = ID/WB stages and L2 bank side.

interface ibex_l2_rf_port_sched_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) ();

    logic                 rd_req;
    logic                 rd_need_a;
    logic                 rd_need_b;
    logic [AddrWidth-1:0] raddr_a;
    logic [AddrWidth-1:0] raddr_b;
    logic [DataWidth-1:0] rdata_a;
    logic [DataWidth-1:0] rdata_b;
    logic                 rd_done;
    logic                 stall;

    logic                 wr_req;
    logic [AddrWidth-1:0] waddr;
    logic [DataWidth-1:0] wdata;
    logic                 wr_full;

    logic [AddrWidth-1:0] l2_addr;
    logic                 l2_we;
    logic [DataWidth-1:0] l2_wdata;
    logic [DataWidth-1:0] l2_rdata;

    modport slave (
        input  rd_req, rd_need_a, rd_need_b, raddr_a, raddr_b,
        output rdata_a, rdata_b, rd_done, stall,
        input  wr_req, waddr, wdata,
        output wr_full,
        output l2_addr, l2_we, l2_wdata,
        input  l2_rdata
    );

    modport master (
        output rd_req, rd_need_a, rd_need_b, raddr_a, raddr_b,
        input  rdata_a, rdata_b, rd_done, stall,
        output wr_req, waddr, wdata,
        input  wr_full,
        input  l2_addr, l2_we, l2_wdata,
        output l2_rdata
    );

endinterface

// File: rtl/ibex_l2_rf_port_sched.sv
// rtl/ibex_l2_rf_port_sched.sv - single-port L2 register-file bank scheduler
//
// Purpose: shares the single L2 register-file port between ID-stage operand reads
//          (A then B) and writebacks. Writebacks are queued in an in-order write
//          buffer that drains whenever the port is not being used for a read.
//          Reads that hit a buffered (or same-cycle) write first drain the buffer.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     ibex_l2_rf_port_sched_if.slave: operand fetch, writeback push, L2 port

module ibex_l2_rf_port_sched #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 5,
    parameter int WrBufDepth = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ibex_l2_rf_port_sched_if.slave        bus
);

    localparam int PtrW = (WrBufDepth > 1) ? $clog2(WrBufDepth) : 1;
    localparam int CntW = $clog2(WrBufDepth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(WrBufDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(WrBufDepth);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StRdA,
        StRdB,
        StDone
    } state_e;

    state_e state_q, state_d;
    state_e idle_next;

    // Write buffer: circular FIFO with per-slot valid bits for the hazard search.
    logic [AddrWidth-1:0]  buf_addr_q [WrBufDepth];
    logic [DataWidth-1:0]  buf_data_q [WrBufDepth];
    logic [WrBufDepth-1:0] buf_valid_q;
    logic [PtrW-1:0]       head_q, tail_q;
    logic [CntW-1:0]       count_q;

    logic [DataWidth-1:0]  rdata_a_q, rdata_b_q;

    logic buf_empty;
    logic wr_full;
    logic push_en;
    logic pop_en;
    logic need_a, need_b;
    logic hit_a, hit_b;
    logic hazard;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty = (count_q == '0);
    // Fullness comes from the registered count only, so a same-cycle pop never frees room.
    assign wr_full   = (count_q == FullCnt);
    // Writes to register 0 are accepted on the handshake but never stored.
    assign push_en   = bus.wr_req && !wr_full && (bus.waddr != '0);
    assign pop_en    = (state_q inside {StIdle, StDrain, StDone}) && !buf_empty;

    // Register 0 is hardwired to zero, so it never needs an L2 read.
    assign need_a = bus.rd_req && bus.rd_need_a && (bus.raddr_a != '0);
    assign need_b = bus.rd_req && bus.rd_need_b && (bus.raddr_b != '0);

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < WrBufDepth; i++) begin
            if (buf_valid_q[i] && (buf_addr_q[i] == bus.raddr_a)) hit_a = 1'b1;
            if (buf_valid_q[i] && (buf_addr_q[i] == bus.raddr_b)) hit_b = 1'b1;
        end
        // A push landing in the same cycle is also newer than the L2 contents.
        if (push_en && (bus.waddr == bus.raddr_a)) hit_a = 1'b1;
        if (push_en && (bus.waddr == bus.raddr_b)) hit_b = 1'b1;
        hazard = (need_a && hit_a) || (need_b && hit_b);
    end

    // Request decode shared by IDLE and by DRAIN once the buffer is empty.
    always_comb begin
        idle_next = StIdle;
        if (bus.rd_req) begin
            if (hazard)      idle_next = StDrain;
            else if (need_a) idle_next = StRdA;
            else if (need_b) idle_next = StRdB;
            else             idle_next = StDone;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = idle_next;
            StDrain: begin
                if (!bus.rd_req)     state_d = StIdle;
                else if (!buf_empty) state_d = StDrain;
                else                 state_d = idle_next;
            end
            StRdA: begin
                if (!bus.rd_req) state_d = StIdle;
                else if (need_b) state_d = StRdB;
                else             state_d = StDone;
            end
            StRdB: begin
                if (!bus.rd_req) state_d = StIdle;
                else             state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer payload needs no reset: slots are only read while their valid bit is set.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            buf_addr_q[tail_q] <= bus.waddr;
            buf_data_q[tail_q] <= bus.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            // Push and pop never address the same slot: a pop needs count>0 and
            // a push needs count<depth, so head!=tail whenever both happen.
            if (push_en) begin
                buf_valid_q[tail_q] <= 1'b1;
                tail_q              <= ptr_inc(tail_q);
            end
            if (pop_en) begin
                buf_valid_q[head_q] <= 1'b0;
                head_q              <= ptr_inc(head_q);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Operand registers: zero operands clear on the request's first cycle,
    // captures only while the request is still held (an abort keeps old values).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (bus.rd_req) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.raddr_a == '0) rdata_a_q <= '0;
                    if (bus.raddr_b == '0) rdata_b_q <= '0;
                end
                StRdA:   rdata_a_q <= bus.l2_rdata;
                StRdB:   rdata_b_q <= bus.l2_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.l2_addr  = '0;
        bus.l2_we    = 1'b0;
        bus.l2_wdata = '0;
        if (pop_en) begin
            bus.l2_addr  = buf_addr_q[head_q];
            bus.l2_we    = 1'b1;
            bus.l2_wdata = buf_data_q[head_q];
        end else if (state_q == StRdA) begin
            bus.l2_addr = bus.raddr_a;
        end else if (state_q == StRdB) begin
            bus.l2_addr = bus.raddr_b;
        end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.rd_done = (state_q == StDone);
    assign bus.stall   = bus.rd_req && !bus.rd_done;
    assign bus.wr_full = wr_full;

endmodule

// File: tb/tb_ibex_l2_rf_port_sched.sv
// tb/tb_ibex_l2_rf_port_sched.sv - self-checking bench for ibex_l2_rf_port_sched

module tb_ibex_l2_rf_port_sched;

    logic clk;
    logic rst_n;

    ibex_l2_rf_port_sched_if #(.DataWidth(32), .AddrWidth(5)) bus ();

    ibex_l2_rf_port_sched #(
        .DataWidth (32),
        .AddrWidth (5),
        .WrBufDepth(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // L2 bank model: combinational read, write at the clock edge.
    logic [31:0] l2_mem [32];
    assign bus.l2_rdata = l2_mem[bus.l2_addr];
    always @(posedge clk) begin
        if (bus.l2_we) l2_mem[bus.l2_addr] <= bus.l2_wdata;
    end

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } rd_t;

    typedef struct {
        logic        na;
        logic        nb;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic [31:0] ea;
        logic [31:0] eb;
        int          lat;
    } vec_t;

    wr_t  wr_q [$];
    rd_t  rd_q [$];
    vec_t vecs [8];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req    = 1'b0;
        bus.rd_need_a = 1'b0;
        bus.rd_need_b = 1'b0;
        bus.raddr_a   = 5'd0;
        bus.raddr_b   = 5'd0;
        bus.wr_req    = 1'b0;
        bus.waddr     = 5'd0;
        bus.wdata     = 32'd0;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input bit accepted);
        bus.wr_req = 1'b1;
        bus.waddr  = a;
        bus.wdata  = d;
        if (accepted && a != 5'd0) wr_q.push_back({a, d});
    endtask

    task automatic start_rd(input logic na, input logic nb, input logic [4:0] aa, input logic [4:0] ab);
        bus.rd_req    = 1'b1;
        bus.rd_need_a = na;
        bus.rd_need_b = nb;
        bus.raddr_a   = aa;
        bus.raddr_b   = ab;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        bit done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            if (bus.rd_done) begin
                done = 1'b1;
            end else begin
                chk({name, "_stall"}, 32'(bus.stall), 32'd1);
                lat++;
                next();
                bus.wr_req = 1'b0;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_stall_at_done"}, 32'(bus.stall), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rdata_a"}, bus.rdata_a, 32'd0);
        chk({name, "_rdata_b"}, bus.rdata_b, 32'd0);
        chk({name, "_rd_done"}, 32'(bus.rd_done), 32'd0);
        chk({name, "_l2_we"}, 32'(bus.l2_we), 32'd0);
        chk({name, "_l2_addr"}, 32'(bus.l2_addr), 32'd0);
        chk({name, "_wr_full"}, 32'(bus.wr_full), 32'd0);
        chk({name, "_stall"}, 32'(bus.stall), 32'd0);
    endtask

    // L2 write scoreboard: every write strobe must match the oldest accepted push.
    always @(negedge clk) begin
        if (rst_n && bus.l2_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL l2_write_unexpected actual_addr=%0d actual_data=%h expected=none",
                         bus.l2_addr, bus.l2_wdata);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("l2_write_addr", 32'(bus.l2_addr), 32'(e.a));
                chk("l2_write_data", bus.l2_wdata, e.d);
            end
        end
    end

    // Read scoreboard: every rd_done pulse must match the oldest issued request.
    always @(negedge clk) begin
        if (rst_n && bus.rd_done) begin
            if (rd_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_done_unexpected actual=1 expected=0");
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                chk("rdata_a", bus.rdata_a, e.a);
                chk("rdata_b", bus.rdata_b, e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          na    nb    aa     ab     pe    pa     pd          ea          eb          lat
        vecs[0] = '{1'b1, 1'b1, 5'd5,  5'd9,  1'b0, 5'd0, 32'h0,     32'h11,     32'h22,     3};
        vecs[1] = '{1'b1, 1'b0, 5'd3,  5'd12, 1'b0, 5'd0, 32'h0,     32'h33,     32'h22,     2};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  5'd12, 1'b0, 5'd0, 32'h0,     32'h33,     32'h44,     2};
        vecs[3] = '{1'b1, 1'b1, 5'd9,  5'd0,  1'b0, 5'd0, 32'h0,     32'h22,     32'h0,      2};
        vecs[4] = '{1'b1, 1'b1, 5'd8,  5'd3,  1'b1, 5'd8, 32'h5A,    32'h5A,     32'h33,     5};
        vecs[5] = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 5'd0, 32'h0,     32'h0,      32'h0,      1};
        vecs[6] = '{1'b0, 1'b0, 5'd5,  5'd9,  1'b0, 5'd0, 32'h0,     32'h0,      32'h0,      1};
        vecs[7] = '{1'b1, 1'b1, 5'd12, 5'd12, 1'b0, 5'd0, 32'h0,     32'h44,     32'h44,     3};

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        next();
        rst_n = 1'b1;

        // Preload L2 through the write buffer; one push per cycle never fills it in IDLE.
        // The register-0 push is accepted but must never reach L2.
        push_wr(5'd5, 32'h11, 1'b1);
        @(negedge clk); chk("preload_full0", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd9, 32'h22, 1'b1);
        @(negedge clk); chk("preload_full1", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd0, 32'hDEAD, 1'b1);
        @(negedge clk); chk("preload_full2", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd3, 32'h33, 1'b1);
        @(negedge clk); chk("preload_full3", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd12, 32'h44, 1'b1);
        @(negedge clk); chk("preload_full4", 32'(bus.wr_full), 32'd0); next();
        idle_inputs();
        repeat (3) next();
        chk("preload_drained", wr_q.size(), 32'd0);

        // Table-driven operand fetches, each starting in IDLE with an empty buffer.
        for (int v = 0; v < 8; v++) begin
            start_rd(vecs[v].na, vecs[v].nb, vecs[v].aa, vecs[v].ab);
            if (vecs[v].pe) push_wr(vecs[v].pa, vecs[v].pd, 1'b1);
            rd_q.push_back({vecs[v].ea, vecs[v].eb});
            wait_done($sformatf("vec%0d", v), vecs[v].lat);
            next();
            idle_inputs();
            repeat (3) next();
        end

        // Buffered write followed by a read of the same register: drain first.
        push_wr(5'd7, 32'hAB, 1'b1);
        next();
        bus.wr_req = 1'b0;
        start_rd(1'b1, 1'b0, 5'd7, 5'd9);
        rd_q.push_back({32'hAB, 32'h44});
        wait_done("raw_drain", 3);
        next();
        idle_inputs();
        repeat (3) next();

        // Buffer fills during RD_A/RD_B; a push while full is refused even as DONE pops.
        start_rd(1'b1, 1'b1, 5'd5, 5'd9);
        rd_q.push_back({32'h11, 32'h22});
        push_wr(5'd20, 32'h66, 1'b1);
        @(negedge clk); chk("full_c0", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd21, 32'h67, 1'b1);
        @(negedge clk); chk("full_c1", 32'(bus.wr_full), 32'd0); next();
        push_wr(5'd22, 32'h68, 1'b0);
        @(negedge clk); chk("full_c2", 32'(bus.wr_full), 32'd1); next();
        @(negedge clk);
        chk("full_c3", 32'(bus.wr_full), 32'd1);
        chk("full_c3_done", 32'(bus.rd_done), 32'd1);
        chk("full_c3_we", 32'(bus.l2_we), 32'd1);
        next();
        bus.rd_req = 1'b0;
        push_wr(5'd22, 32'h68, 1'b1);
        @(negedge clk);
        chk("full_c4", 32'(bus.wr_full), 32'd0);
        chk("full_c4_we", 32'(bus.l2_we), 32'd1);
        next();
        idle_inputs();
        @(negedge clk); chk("full_c5_we", 32'(bus.l2_we), 32'd1); next();
        repeat (2) next();
        chk("full_drained", wr_q.size(), 32'd0);

        // Abort during RD_A: no pulse, operands unchanged, the pending write drains.
        start_rd(1'b1, 1'b1, 5'd12, 5'd3);
        next();
        bus.rd_req = 1'b0;
        push_wr(5'd23, 32'h69, 1'b1);
        @(negedge clk);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_rda_we", 32'(bus.l2_we), 32'd0);
        next();
        idle_inputs();
        @(negedge clk);
        chk("abort_idle_we", 32'(bus.l2_we), 32'd1);
        chk("abort_no_done", 32'(bus.rd_done), 32'd0);
        next();
        repeat (3) next();
        chk("abort_rdata_a", bus.rdata_a, 32'h11);
        chk("abort_rdata_b", bus.rdata_b, 32'h22);
        chk("abort_drained", wr_q.size(), 32'd0);

        // Reset while draining with buffered writes pending: they must be lost.
        start_rd(1'b1, 1'b1, 5'd5, 5'd9);
        push_wr(5'd14, 32'h0E, 1'b1);
        next();
        push_wr(5'd15, 32'h0F, 1'b1);
        next();
        idle_inputs();
        @(negedge clk); chk("rst_seq_full_rdb", 32'(bus.wr_full), 32'd1); next();
        start_rd(1'b1, 1'b0, 5'd15, 5'd0);
        @(negedge clk);
        chk("rst_seq_full_idle", 32'(bus.wr_full), 32'd1);
        chk("rst_seq_stall_idle", 32'(bus.stall), 32'd1);
        next();
        rst_n = 1'b0;
        idle_inputs();
        wr_q.delete();
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) next();
        rst_n = 1'b1;
        repeat (6) next();

        chk("final_wr_q_empty", wr_q.size(), 32'd0);
        chk("final_rd_q_empty", rd_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
